// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the parameterised synchronous FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_AE_LVL = 2;
  localparam int DEF_AF_LVL = DEF_DEPTH - 2;

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port whose output holds between reads.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Only the read register is cleared; the array itself is left uninitialised.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered status flags, one-cycle read latency and overflow/underflow pulses.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AE_LVL = DEF_AE_LVL,
  parameter int AF_LVL = DEPTH - 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              w_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              r_data,
  output logic                          valid,
  output logic                          ept,
  output logic                          ful,
  output logic                          almost_ept,
  output logic                          almost_ful,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          ovf,
  output logic                          udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);

  if ((DEPTH < 2) || (DEPTH > 1024) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two in 2..1024");
  end
  if (AE_LVL >= AF_LVL) begin : g_bad_levels
    $error("param_sync_fifo: AE_LVL must be below AF_LVL");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ept_q, ful_q, aept_q, aful_q;
  logic          valid_q, ovf_q, udf_q;
  logic          push_ok, pop_ok;

  // Acceptance is judged against the registered flags, so a push into an empty
  // FIFO never makes that word poppable in the same cycle and vice versa when full.
  assign push_ok = reset && push && !ful_q;
  assign pop_ok  = reset && pop  && !ept_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // Flags are derived from next-state occupancy so they change on the causing edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ept_q    <= 1'b1;
      ful_q    <= 1'b0;
      aept_q   <= 1'b1;
      aful_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ept_q    <= (count_d == '0);
      ful_q    <= (count_d == DEPTH_C);
      aept_q   <= (count_d <= AE_C);
      aful_q   <= (count_d >= AF_C);
      valid_q  <= pop_ok;
      ovf_q    <= push && ful_q;
      udf_q    <= pop && ept_q;
    end
  end

  fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clock    (clock),
    .reset    (reset),
    .wr_en_i  (push_ok),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(w_data),
    .rd_en_i  (pop_ok),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(r_data)
  );

  assign valid      = valid_q;
  assign ept        = ept_q;
  assign ful        = ful_q;
  assign almost_ept = aept_q;
  assign almost_ful = aful_q;
  assign count      = count_q;
  assign ovf        = ovf_q;
  assign udf        = udf_q;

  // The pulses describe the previous cycle's flags, hence the $past references.
  a_excl: assert property (@(posedge clock) disable iff (!reset) !(ept_q && ful_q));
  a_cnt:  assert property (@(posedge clock) disable iff (!reset) count_q <= DEPTH_C);
  a_ovf:  assert property (@(posedge clock) disable iff (!reset) ovf_q |-> $past(ful_q));
  a_udf:  assert property (@(posedge clock) disable iff (!reset) udf_q |-> $past(ept_q));

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomised scoreboard bench for param_sync_fifo against a queue-based reference model.
module tb_param_sync_fifo;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int AE_LVL = 2;
  localparam int AF_LVL = 14;

  logic             clock = 1'b0;
  logic             reset;
  logic             push;
  logic [WIDTH-1:0] w_data;
  logic             pop;
  logic [WIDTH-1:0] r_data;
  logic             valid, ept, ful, almost_ept, almost_ful, ovf, udf;
  logic [4:0]       count;

  logic [WIDTH-1:0] model[$];
  logic [WIDTH-1:0] expQ[$];
  logic [WIDTH-1:0] holdExp = '0;
  bit               expOvf, expUdf, expValid;
  int               checks = 0;
  int               errors = 0;

  param_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AE_LVL(AE_LVL),
    .AF_LVL(AF_LVL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .w_data    (w_data),
    .pop       (pop),
    .r_data    (r_data),
    .valid     (valid),
    .ept       (ept),
    .ful       (ful),
    .almost_ept(almost_ept),
    .almost_ful(almost_ful),
    .count     (count),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Expected status is computed from the model's occupancy after the edge.
  task automatic checkOutput();
    int n;
    n = model.size();
    check("count", int'(count), n);
    check("ept", int'(ept), int'(n == 0));
    check("ful", int'(ful), int'(n == DEPTH));
    check("almost_ept", int'(almost_ept), int'(n <= AE_LVL));
    check("almost_ful", int'(almost_ful), int'(n >= AF_LVL));
    check("ovf", int'(ovf), int'(expOvf));
    check("udf", int'(udf), int'(expUdf));
    check("valid", int'(valid), int'(expValid));
  endtask

  task automatic applyStimulus(input bit p, input logic [WIDTH-1:0] d, input bit q);
    bit wasEmpty, wasFull;
    wasEmpty = (model.size() == 0);
    wasFull  = (model.size() == DEPTH);
    push     = p;
    w_data   = d;
    pop      = q;
    expOvf   = p && wasFull;
    expUdf   = q && wasEmpty;
    expValid = q && !wasEmpty;
    if (expValid) expQ.push_back(model.pop_front());
    if (p && !wasFull) model.push_back(d);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    reset  = 1'b0;
    push   = 1'b1;
    pop    = 1'b1;
    w_data = 8'h5A;
    model.delete();
    expQ.delete();
    expOvf   = 1'b0;
    expUdf   = 1'b0;
    expValid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    checkOutput();
  endtask

  // Monitor: every presented word must match the oldest expected word; r_data holds otherwise.
  initial begin
    logic [WIDTH-1:0] w;
    forever begin
      @(negedge clock);
      if (!reset) begin
        holdExp = '0;
      end else if (valid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard: valid with no expected word, r_data %0h", r_data);
        end else begin
          w = expQ.pop_front();
          check("r_data", int'(r_data), int'(w));
          holdExp = w;
        end
      end else begin
        check("r_data_hold", int'(r_data), int'(holdExp));
      end
    end
  end

  initial begin
    int pushPct, popPct;
    doReset();

    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h77, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);

    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    doReset();
    applyStimulus(1'b0, 8'h00, 1'b1);

    for (int phase = 0; phase < 6; phase++) begin
      pushPct = (phase % 2 == 0) ? 80 : 25;
      popPct  = (phase % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 250; i++) begin
        applyStimulus($urandom_range(0, 99) < pushPct, 8'($urandom),
                      $urandom_range(0, 99) < popPct);
      end
    end

    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clock);
    #1;
    check("expQ_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 Parameter DEPTH, default 16, entry count; power of two, 2..1024.
REQ-003 Parameter AE_LVL, default 2, almost-empty threshold (count <= AE_LVL).
REQ-004 Parameter AF_LVL, default DEPTH-2, almost-full threshold (count >= AF_LVL).
REQ-005 clock  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 push  in  1  write request; w_data captured when push=1 and ful=0.
REQ-008 w_data  in  WIDTH  write data.
REQ-009 pop  in  1  read request; accepted when pop=1 and ept=0.
REQ-010 r_data  out  WIDTH  read data, qualified by valid.
REQ-011 valid  out  1  r_data holds the word popped on the previous cycle.
REQ-012 ept  out  1  count == 0.
REQ-013 ful  out  1  count == DEPTH.
REQ-014 almost_ept  out  1  count <= AE_LVL.
REQ-015 almost_ful  out  1  count >= AF_LVL.
REQ-016 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-017 ovf  out  1  one-cycle pulse: push attempted while ful=1.
REQ-018 udf  out  1  one-cycle pulse: pop attempted while ept=1.

Function
REQ-019 All flags, count and pulses SHALL be registered, reflecting state after the last clock edge.
REQ-020 Read latency SHALL be one cycle: accepted pop at edge N -> r_data/valid at edge N+1; valid=0 when no pop accepted.
REQ-021 r_data SHALL hold its last value when valid=0.
REQ-022 Word order SHALL be strictly first-in first-out.
REQ-023 Write/read pointers SHALL be log2(DEPTH) bits and wrap DEPTH-1 -> 0 without loss.
REQ-024 count: +1 on accepted push only, -1 on accepted pop only, unchanged on both or neither.
REQ-025 Push while ful=1 SHALL be dropped (no pointer/count change) and assert ovf next cycle.
REQ-026 Pop while ept=1 SHALL be ignored (valid=0) and assert udf next cycle.
REQ-027 Push+pop while ept=1: push accepted, pop rejected with udf; count becomes 1.
REQ-028 Push+pop while ful=1: pop accepted, push rejected with ovf; count becomes DEPTH-1.
REQ-029 Push+pop otherwise: both accepted, count unchanged.
REQ-030 ept and ful SHALL never be 1 simultaneously.
REQ-031 Flag updates SHALL take effect on the edge of the causing push/pop.

Reset
REQ-032 When reset=0 at a rising edge: pointers=0, count=0, ept=1, ful=0, almost_ept=1, almost_ful=0 (AF_LVL>0), valid=0, ovf=0, udf=0, r_data=0.
REQ-033 Reset mid-operation SHALL discard all contents; push/pop ignored while reset=0.
REQ-034 Memory array contents need not be reset.

Structure
REQ-035 Package fifo_pkg SHALL hold default WIDTH/DEPTH/AE_LVL/AF_LVL constants and a count-width function.
REQ-036 Storage SHALL be sub-module fifo_mem (1 write port, 1 registered read port, WIDTH x DEPTH).
REQ-037 Elaboration SHALL fail if DEPTH is not a power of two or AE_LVL >= AF_LVL.
REQ-038 Interface SHALL provide concurrent assertions: ept/ful exclusive, count <= DEPTH, ovf only when ful, udf only when ept (disabled while reset=0).

Verification (WIDTH=8, DEPTH=16, AE_LVL=2, AF_LVL=14)
REQ-039 Push 0x01..0x10 then pop 16 -> r_data 0x01..0x10 in order, valid each cycle after pop; ful at count 16, ept after last pop.
REQ-040 Full FIFO, push 0xAA -> ovf=1 one cycle, count stays 16, 0xAA never read.
REQ-041 Empty FIFO, pop -> udf=1 one cycle, valid=0; push+pop same cycle -> count=1, udf=1.
REQ-042 Fill to 16, push+pop same cycle -> ovf=1, count=15, first word out 0x01.
REQ-043 40 push/pop pairs at count 8 -> pointers wrap twice, data intact, count stays 8; almost_ept at count 2, almost_ful at 14.
REQ-044 Fill to 10, reset=0 one cycle -> count=0, ept=1, valid=0; next pop -> udf=1.
